// File: rtl/v_arith_issue_ctrl.sv
// Vector arithmetic issue controller: decodes OPIV*/OPMV* instructions, handles vsetvli,
// and sequences element groups to the ALU lanes. Optional macro V_ARITH_MASK_EN adds mask_en_o.
module v_arith_issue_ctrl #(
  parameter int VLEN  = 1024,
  parameter int LANES = 4,
  parameter int VL_W  = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      rs1_data_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  output logic [4:0]       alu_op_o,
  output logic [1:0]       src_sel_o,
  output logic [31:0]      scalar_o,
  output logic [4:0]       vs1_o,
  output logic [4:0]       vs2_o,
  output logic [4:0]       vd_o,
  output logic [VL_W-1:0]  group_idx_o,
  output logic [LANES-1:0] lane_en_o,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [VL_W-1:0]  vl_o,
  output logic [1:0]       sew_o,
  output logic             done_o,
  output logic             illegal_o
`ifdef V_ARITH_MASK_EN
  ,
  output logic             mask_en_o
`endif
);

  localparam logic [6:0] OPC_V = 7'b1010111;

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;

  state_t           state_q;
  logic             ready_q;
  logic [4:0]       op_q;
  logic [1:0]       src_q;
  logic [31:0]      scalar_q;
  logic [4:0]       vs1_q, vs2_q, vd_q;
  logic [VL_W-1:0]  grp_q;
  logic [LANES-1:0] lane_q;
  logic             valid_q;
  logic [VL_W-1:0]  vl_q;
  logic [1:0]       sew_q;
  logic             done_q;
  logic             illegal_q;
  logic             mask_q;

  logic [5:0] funct6;
  logic [2:0] funct3;
  logic       vm;
  logic       is_vec, is_opi, is_opm, is_ivi, is_x, is_cfg, cfg_ok;

  assign funct6 = instr_i[31:26];
  assign funct3 = instr_i[14:12];
  assign vm     = instr_i[25];
  assign is_vec = (instr_i[6:0] == OPC_V);
  assign is_opi = (funct3 == 3'b000) || (funct3 == 3'b011) || (funct3 == 3'b100);
  assign is_opm = (funct3 == 3'b010) || (funct3 == 3'b110);
  assign is_ivi = (funct3 == 3'b011);
  assign is_x   = (funct3 == 3'b100) || (funct3 == 3'b110);
  assign is_cfg = (funct3 == 3'b111);
  // Only vsetvli with zimm[5:3] in 0..2 is accepted as a configuration.
  assign cfg_ok = !instr_i[31] && !instr_i[25] && (instr_i[24:23] != 2'b11);

  logic [31:0]     vlmax_d;
  logic [VL_W-1:0] vl_d;

  assign vlmax_d = 32'(VLEN) >> (32'd3 + {30'd0, instr_i[24:23]});
  assign vl_d    = (rs1_data_i < vlmax_d) ? rs1_data_i[VL_W-1:0] : vlmax_d[VL_W-1:0];

  logic [4:0]  op_d;
  logic [1:0]  src_d;
  logic [31:0] scalar_d;
  logic        legal_d;
  logic        known, mul_fam, ivi_bad, mask_ok, is_shift;

  always_comb begin
    op_d  = 5'd0;
    known = 1'b1;
    casez (funct6)
      6'b000000: op_d = 5'd0;
      6'b000010: op_d = 5'd1;
      6'b001001: op_d = 5'd2;
      6'b001010: op_d = 5'd3;
      6'b001011: op_d = 5'd4;
      6'b010111: op_d = 5'd5;
      6'b100101: op_d = is_opm ? 5'd6 : 5'd10;
      6'b100110: op_d = 5'd7;
      6'b100111: op_d = 5'd8;
      6'b100100: op_d = 5'd9;
      6'b101000: op_d = 5'd11;
      6'b101001: op_d = 5'd12;
      6'b011???: op_d = 5'd13 + {2'b00, funct6[2:0]};
      6'b000100: op_d = 5'd21;
      6'b000101: op_d = 5'd22;
      default:   known = 1'b0;
    endcase
    mul_fam  = (op_d >= 5'd6) && (op_d <= 5'd9);
    ivi_bad  = is_ivi && ((op_d == 5'd1) || (op_d == 5'd15) || (op_d == 5'd16) ||
                          (op_d == 5'd21) || (op_d == 5'd22));
`ifdef V_ARITH_MASK_EN
    mask_ok  = 1'b1;
`else
    mask_ok  = (op_d == 5'd5) ? !vm : vm;
`endif
    legal_d  = known && (mul_fam ? is_opm : is_opi) && !ivi_bad && mask_ok;
    is_shift = (op_d == 5'd10) || (op_d == 5'd11) || (op_d == 5'd12);
    if (is_ivi) begin
      src_d    = 2'b10;
      scalar_d = is_shift ? {27'd0, instr_i[19:15]} : {{27{instr_i[19]}}, instr_i[19:15]};
    end else if (is_x) begin
      src_d    = 2'b01;
      scalar_d = rs1_data_i;
    end else begin
      src_d    = 2'b00;
      scalar_d = 32'd0;
    end
  end

  logic [VL_W:0]    grp_sum;
  logic [VL_W:0]    vl_ext;
  logic [LANES-1:0] lane_first, lane_next;

  assign grp_sum = {1'b0, grp_q} + (VL_W+1)'(LANES);
  assign vl_ext  = {1'b0, vl_q};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_first[gi] = (VL_W+1)'(gi) < vl_ext;
    assign lane_next[gi]  = (grp_sum + (VL_W+1)'(gi)) < vl_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      op_q      <= '0;
      src_q     <= '0;
      scalar_q  <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      grp_q     <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      vl_q      <= '0;
      sew_q     <= 2'b10;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mask_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            if (!is_vec) begin
              illegal_q <= 1'b1;
            end else if (is_cfg) begin
              if (cfg_ok) begin
                sew_q   <= instr_i[24:23];
                vl_q    <= vl_d;
                done_q  <= 1'b1;
                ready_q <= 1'b0;
                state_q <= FIN;
              end else begin
                illegal_q <= 1'b1;
              end
            end else if (!legal_d) begin
              illegal_q <= 1'b1;
            end else begin
              op_q     <= op_d;
              src_q    <= src_d;
              scalar_q <= scalar_d;
              vs1_q    <= instr_i[19:15];
              vs2_q    <= instr_i[24:20];
              vd_q     <= instr_i[11:7];
              mask_q   <= !vm;
              grp_q    <= '0;
              ready_q  <= 1'b0;
              // An empty vector completes without touching the lanes.
              if (vl_q == '0) begin
                done_q  <= 1'b1;
                state_q <= FIN;
              end else begin
                lane_q  <= lane_first;
                valid_q <= 1'b1;
                state_q <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          if (issue_ready_i) begin
            if (grp_sum >= vl_ext) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              grp_q  <= grp_sum[VL_W-1:0];
              lane_q <= lane_next;
            end
          end
        end
        FIN: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign alu_op_o      = op_q;
  assign src_sel_o     = src_q;
  assign scalar_o      = scalar_q;
  assign vs1_o         = vs1_q;
  assign vs2_o         = vs2_q;
  assign vd_o          = vd_q;
  assign group_idx_o   = grp_q;
  assign lane_en_o     = lane_q;
  assign issue_valid_o = valid_q;
  assign vl_o          = vl_q;
  assign sew_o         = sew_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
`ifdef V_ARITH_MASK_EN
  assign mask_en_o     = mask_q;
`else
  logic unused_mask;
  assign unused_mask   = mask_q;
`endif

endmodule

// File: tb/tb_v_arith_issue_ctrl.sv
// Self-checking bench for v_arith_issue_ctrl: table of instructions plus
// hand-written stall/reset and vl=0 sequences, with an issue scoreboard.
module tb_v_arith_issue_ctrl;
  localparam int LANES = 4;
  localparam int VL_W  = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [4:0]  alu_op_o;
  logic [1:0]  src_sel_o;
  logic [31:0] scalar_o;
  logic [4:0]  vs1_o, vs2_o, vd_o;
  logic [VL_W-1:0]  group_idx_o;
  logic [LANES-1:0] lane_en_o;
  logic        issue_valid_o;
  logic        issue_ready_i = 1'b0;
  logic [VL_W-1:0] vl_o;
  logic [1:0]  sew_o;
  logic        done_o, illegal_o;
`ifdef V_ARITH_MASK_EN
  logic        mask_en_o;
`endif

  v_arith_issue_ctrl #(.VLEN(1024), .LANES(LANES), .VL_W(VL_W)) dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .rs1_data_i(rs1_data_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .alu_op_o(alu_op_o), .src_sel_o(src_sel_o), .scalar_o(scalar_o),
    .vs1_o(vs1_o), .vs2_o(vs2_o), .vd_o(vd_o), .group_idx_o(group_idx_o),
    .lane_en_o(lane_en_o), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .vl_o(vl_o), .sew_o(sew_o), .done_o(done_o), .illegal_o(illegal_o)
`ifdef V_ARITH_MASK_EN
    , .mask_en_o(mask_en_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       op;
    logic [1:0]       src;
    logic [31:0]      sc;
    logic [4:0]       vs1, vs2, vd;
    logic [VL_W-1:0]  grp;
    logic [LANES-1:0] lane;
  } iss_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] rs1;
    bit          ill;
    logic [4:0]  op;
    logic [1:0]  src;
    logic [31:0] sc;
  } vec_t;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_vl = 0;
  iss_t got_q[$];
  iss_t exp_q[$];
  vec_t tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records every group the lanes accept.
  always @(negedge clk)
    if (reset && issue_valid_o && issue_ready_i)
      got_q.push_back({alu_op_o, src_sel_o, scalar_o, vs1_o, vs2_o, vd_o, group_idx_o, lane_en_o});

  function automatic logic [31:0] enc(logic [5:0] f6, logic vmb, logic [4:0] vs2,
                                      logic [4:0] vs1, logic [2:0] f3, logic [4:0] vd);
    return {f6, vmb, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r1, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!instr_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL send_ready_timeout: instr_ready_o low for %0d cycles", t);
    end
    instr_i = ins;
    rs1_data_i = r1;
    instr_valid_i = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done_o) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done_o within 200 cycles");
    end
  endtask

  task automatic cfg(input logic [2:0] sew3, input logic [31:0] r1, input int evl,
                     input logic [1:0] esew, input bit ill);
    int acc;
    logic [31:0] ins;
    ins = {1'b0, 5'd0, sew3, 3'd0, 5'd1, 3'b111, 5'd0, 7'b1010111};
    send(ins, r1, acc);
    @(negedge clk);
    if (ill) chk("cfg_illegal", illegal_o, 1);
    else     chk("cfg_done", done_o, 1);
    chk("cfg_vl", vl_o, evl);
    chk("cfg_sew", sew_o, esew);
    chk("cfg_no_issue", issue_valid_o, 0);
    @(negedge clk);
    chk("cfg_pulse_end", {done_o, illegal_o}, 0);
    chk("cfg_ready", instr_ready_o, 1);
    cur_vl = evl;
    $display("cfg sew=%0d rs1=%0d -> vl=%0d sew=%0d ill=%0d", sew3, r1, vl_o, sew_o, ill);
  endtask

  task automatic run_arith(input vec_t v, input int idx);
    int n0, acc, dc, ng;
    iss_t e, g;
    logic [LANES-1:0] lane;
    n0 = got_q.size();
    issue_ready_i = 1'b1;
    if (v.ill) begin
      send(v.ins, v.rs1, acc);
      @(negedge clk);
      chk("illegal_pulse", illegal_o, 1);
      chk("illegal_no_issue", issue_valid_o, 0);
      @(negedge clk);
      chk("illegal_ready_back", instr_ready_o, 1);
      chk("illegal_pulse_end", illegal_o, 0);
      @(negedge clk);
      chk("illegal_handshakes", got_q.size() - n0, 0);
    end else begin
      ng = (cur_vl + LANES - 1) / LANES;
      for (int gi = 0; gi < ng; gi++) begin
        for (int k = 0; k < LANES; k++) lane[k] = (gi * LANES + k) < cur_vl;
        e = {v.op, v.src, v.sc, v.ins[19:15], v.ins[24:20], v.ins[11:7],
             VL_W'(gi * LANES), lane};
        exp_q.push_back(e);
      end
      send(v.ins, v.rs1, acc);
      wait_done(dc);
      if (dc >= 0) chk("latency", dc - acc, ng + 1);
      chk("group_count", got_q.size() - n0, ng);
`ifdef V_ARITH_MASK_EN
      chk("mask_en", mask_en_o, ~v.ins[25]);
`endif
      for (int i = n0; i < got_q.size(); i++) begin
        g = got_q[i];
        if (exp_q.size() > 0) chk("issue_fields", g, exp_q.pop_front());
      end
      exp_q.delete();
      @(negedge clk);
      chk("done_pulse_end", done_o, 0);
      chk("ready_after_done", instr_ready_o, 1);
    end
    $display("vec %0d instr=%08h rs1=%08h ill=%0d vl=%0d groups=%0d",
             idx, v.ins, v.rs1, v.ill, cur_vl, got_q.size() - n0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n0, dones;
    iss_t act;
    logic [31:0] vadd;
    vadd = enc(6'b000000, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3);

    // Legal and illegal arithmetic instructions, applied with vl=10.
    tbl.push_back('{vadd, 32'd0, 1'b0, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b100101, 1'b1, 5'd4, 5'd9, 3'b110, 5'd5), 32'd7, 1'b0, 5'd6, 2'b01, 32'd7});
    tbl.push_back('{enc(6'b100101, 1'b1, 5'd4, 5'd31, 3'b011, 5'd6), 32'd0, 1'b0, 5'd10, 2'b10, 32'd31});
    tbl.push_back('{enc(6'b000000, 1'b1, 5'd7, 5'd31, 3'b011, 5'd8), 32'd0, 1'b0, 5'd0, 2'b10, 32'hFFFF_FFFF});
    tbl.push_back('{enc(6'b001011, 1'b1, 5'd1, 5'd2, 3'b100, 5'd9), 32'hDEAD_BEEF, 1'b0, 5'd4, 2'b01, 32'hDEAD_BEEF});
    tbl.push_back('{enc(6'b011111, 1'b1, 5'd3, 5'd5, 3'b011, 5'd10), 32'd0, 1'b0, 5'd20, 2'b10, 32'd5});
    tbl.push_back('{enc(6'b000101, 1'b1, 5'd11, 5'd12, 3'b000, 5'd13), 32'd0, 1'b0, 5'd22, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b100100, 1'b1, 5'd14, 5'd15, 3'b010, 5'd16), 32'd0, 1'b0, 5'd9, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b101001, 1'b1, 5'd17, 5'd16, 3'b011, 5'd18), 32'd0, 1'b0, 5'd12, 2'b10, 32'd16});
    tbl.push_back('{enc(6'b010111, 1'b0, 5'd19, 5'd20, 3'b000, 5'd21), 32'd0, 1'b0, 5'd5, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b101000, 1'b1, 5'd2, 5'd3, 3'b100, 5'd4), 32'd3, 1'b0, 5'd11, 2'b01, 32'd3});
    tbl.push_back('{enc(6'b011010, 1'b1, 5'd2, 5'd3, 3'b100, 5'd4), 32'd9, 1'b0, 5'd15, 2'b01, 32'd9});
    tbl.push_back('{enc(6'b100110, 1'b1, 5'd2, 5'd3, 3'b110, 5'd4), 32'd5, 1'b0, 5'd7, 2'b01, 32'd5});
    tbl.push_back('{enc(6'b000010, 1'b1, 5'd2, 5'd3, 3'b011, 5'd4), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{{vadd[31:7], 7'b0100111}, 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b100111, 1'b1, 5'd2, 5'd3, 3'b000, 5'd4), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b000001, 1'b1, 5'd2, 5'd3, 3'b000, 5'd4), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b011011, 1'b1, 5'd2, 5'd3, 3'b011, 5'd4), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b000000, 1'b1, 5'd2, 5'd3, 3'b010, 5'd4), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
`ifdef V_ARITH_MASK_EN
    tbl.push_back('{enc(6'b000000, 1'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0, 1'b0, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b010111, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0, 1'b0, 5'd5, 2'b00, 32'd0});
`else
    tbl.push_back('{enc(6'b000000, 1'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
    tbl.push_back('{enc(6'b010111, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0, 1'b1, 5'd0, 2'b00, 32'd0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready_o, 1);
    chk("rst_valid", issue_valid_o, 0);
    chk("rst_vl", vl_o, 0);
    chk("rst_sew", sew_o, 2'b10);
    chk("rst_pulses", {done_o, illegal_o}, 0);
    chk("rst_fields", {alu_op_o, src_sel_o, scalar_o, group_idx_o, lane_en_o}, 0);
    reset = 1'b1;

    // Configuration instructions
    cfg(3'b010, 32'd100, 32, 2'b10, 1'b0);
    cfg(3'b000, 32'd300, 128, 2'b00, 1'b0);
    cfg(3'b011, 32'd5, 128, 2'b00, 1'b1);
    cfg(3'b001, 32'd5, 5, 2'b01, 1'b0);
    run_arith(tbl[0], 100);
    cfg(3'b010, 32'd10, 10, 2'b10, 1'b0);

    foreach (tbl[i]) run_arith(tbl[i], i);

    // Stall with ready 0,0,1 then reset mid-sequence.
    issue_ready_i = 1'b0;
    n0 = got_q.size();
    send(vadd, 32'd0, acc);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      act = {alu_op_o, src_sel_o, scalar_o, vs1_o, vs2_o, vd_o, group_idx_o, lane_en_o};
      chk("stall_valid", issue_valid_o, 1);
      chk("stall_hold", act, {5'd0, 2'b00, 32'd0, 5'd1, 5'd2, 5'd3, 11'd0, 4'b1111});
    end
    @(posedge clk);
    #1 issue_ready_i = 1'b1;
    @(posedge clk);
    #1 issue_ready_i = 1'b0;
    @(negedge clk);
    chk("stall_one_hs", got_q.size() - n0, 1);
    chk("stall_next_grp", {issue_valid_o, group_idx_o, lane_en_o}, {1'b1, 11'd4, 4'b1111});
    reset = 1'b0;
    #1;
    chk("abort_valid", issue_valid_o, 0);
    chk("abort_vl", vl_o, 0);
    chk("abort_sew", sew_o, 2'b10);
    chk("abort_ready", instr_ready_o, 1);
    @(negedge clk);
    reset = 1'b1;
    cur_vl = 0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("abort_no_done", dones, 0);
    $display("stall/abort sequence groups=%0d", got_q.size() - n0);

    // vl=0: completion without any group.
    cfg(3'b010, 32'd0, 0, 2'b10, 1'b0);
    run_arith('{enc(6'b000000, 1'b1, 5'd2, 5'd3, 3'b100, 5'd4), 32'd1, 1'b0, 5'd0, 2'b01, 32'd1}, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
